pagerank_iter_sched: RTL and testbench

//  Iteration sequencer for the PageRank datapath. Runs a requested number of

---
 rtl/pagerank_iter_sched.sv | 209 ++++++++++++++++++++
 tb/tb_pagerank_iter_sched.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pagerank_iter_sched.sv
// ---------------------------------------------------------------------------
// pagerank_iter_sched
//
// Iteration sequencer for the PageRank datapath. A start request carries the
// number of rank-update iterations to run. Each iteration walks every node
// once: an update request per node goes to the rank engine (reading the
// current source bank) and each engine result is written into the opposite
// bank. After the last result of an iteration the banks swap. When all
// iterations are done a single completion response reports the bank that
// holds the final ranks and the number of iterations completed.
//
// Handshakes: every channel uses valid/ready. A transfer happens on a rising
// clk edge where both valid and ready are high. A valid that is raised stays
// up with stable payload until the transfer. Ready may depend on valid only
// through eng_resp -> wr_en, which is a same-cycle combinational path.
//
// Ports
//   clk, reset         clock; asynchronous active-high reset
//   in_req_*           start request (iters to run), ready only while idle
//   out_resp_*         completion (final bank, iterations completed)
//   eng_req_*          update request to engine: node index, source bank
//   eng_resp_*         engine result, returned in request order
//   wr_en/bank/node    bank write strobe for the accepted engine result
//   fsm_state          current sequencer state (IDLE=0 RUN=1 SWAP=2 DONE=3)
// ---------------------------------------------------------------------------
module pagerank_iter_sched #(
    parameter int NODES     = 8,
    parameter int ITER_BITS = 8,
    parameter int MAX_OUT   = 4
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       in_req_val,
    output logic                       in_req_rdy,
    input  logic [ITER_BITS-1:0]       in_req_iters,

    output logic                       out_resp_val,
    input  logic                       out_resp_rdy,
    output logic                       out_resp_bank,
    output logic [ITER_BITS-1:0]       out_resp_iters,

    output logic                       eng_req_val,
    input  logic                       eng_req_rdy,
    output logic [$clog2(NODES)-1:0]   eng_req_node,
    output logic                       eng_req_bank,

    input  logic                       eng_resp_val,
    output logic                       eng_resp_rdy,

    output logic                       wr_en,
    output logic                       wr_bank,
    output logic [$clog2(NODES)-1:0]   wr_node,

    output logic [1:0]                 fsm_state
);

    localparam int NW = $clog2(NODES);
    localparam int OW = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SWAP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 cur_bank_q, cur_bank_d;
    logic [ITER_BITS-1:0] iters_q, iters_d;
    logic [ITER_BITS-1:0] iter_cnt_q, iter_cnt_d;
    // issue_ptr needs one extra bit so it can sit at NODES once every node
    // of the iteration has been issued.
    logic [NW:0]          issue_ptr_q, issue_ptr_d;
    logic [NW-1:0]        resp_ptr_q, resp_ptr_d;
    logic [OW-1:0]        outstanding_q, outstanding_d;

    logic                 req_go;
    logic                 resp_go;
    logic [ITER_BITS-1:0] iter_next;

    assign iter_next = iter_cnt_q + ITER_BITS'(1);
    assign fsm_state = state_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cur_bank_q    <= 1'b0;
            iters_q       <= '0;
            iter_cnt_q    <= '0;
            issue_ptr_q   <= '0;
            resp_ptr_q    <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            cur_bank_q    <= cur_bank_d;
            iters_q       <= iters_d;
            iter_cnt_q    <= iter_cnt_d;
            issue_ptr_q   <= issue_ptr_d;
            resp_ptr_q    <= resp_ptr_d;
            outstanding_q <= outstanding_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        cur_bank_d     = cur_bank_q;
        iters_d        = iters_q;
        iter_cnt_d     = iter_cnt_q;
        issue_ptr_d    = issue_ptr_q;
        resp_ptr_d     = resp_ptr_q;
        outstanding_d  = outstanding_q;

        in_req_rdy     = 1'b0;
        out_resp_val   = 1'b0;
        out_resp_bank  = 1'b0;
        out_resp_iters = '0;
        eng_req_val    = 1'b0;
        eng_req_node   = '0;
        eng_req_bank   = 1'b0;
        eng_resp_rdy   = 1'b0;
        wr_en          = 1'b0;
        wr_bank        = 1'b0;
        wr_node        = '0;
        req_go         = 1'b0;
        resp_go        = 1'b0;

        case (state_q)
            IDLE: begin
                in_req_rdy = 1'b1;
                if (in_req_val) begin
                    iters_d       = in_req_iters;
                    cur_bank_d    = 1'b0;
                    iter_cnt_d    = '0;
                    issue_ptr_d   = '0;
                    resp_ptr_d    = '0;
                    outstanding_d = '0;
                    // A zero-iteration run completes immediately in bank 0.
                    state_d       = (in_req_iters != '0) ? RUN : DONE;
                end
            end

            RUN: begin
                // Throttle on both the per-iteration node count and the
                // engine's in-flight window.
                eng_req_val  = (issue_ptr_q < (NW + 1)'(NODES)) &&
                               (outstanding_q < OW'(MAX_OUT));
                eng_req_node = issue_ptr_q[NW-1:0];
                eng_req_bank = cur_bank_q;
                eng_resp_rdy = 1'b1;

                req_go  = eng_req_val & eng_req_rdy;
                resp_go = eng_resp_val;

                // Results come back in request order, so resp_ptr names the
                // node each accepted result belongs to.
                wr_en   = resp_go;
                wr_bank = ~cur_bank_q;
                wr_node = resp_ptr_q;

                if (req_go) begin
                    issue_ptr_d = issue_ptr_q + (NW + 1)'(1);
                end
                if (resp_go) begin
                    resp_ptr_d = resp_ptr_q + NW'(1);
                end

                case ({req_go, resp_go})
                    2'b10:   outstanding_d = outstanding_q + OW'(1);
                    2'b01:   outstanding_d = outstanding_q - OW'(1);
                    default: outstanding_d = outstanding_q;
                endcase

                if (resp_go && (resp_ptr_q == NW'(NODES - 1))) begin
                    state_d = SWAP;
                end
            end

            SWAP: begin
                cur_bank_d    = ~cur_bank_q;
                iter_cnt_d    = iter_next;
                issue_ptr_d   = '0;
                resp_ptr_d    = '0;
                outstanding_d = '0;
                state_d       = (iter_next == iters_q) ? DONE : RUN;
            end

            DONE: begin
                out_resp_val   = 1'b1;
                out_resp_bank  = cur_bank_q;
                out_resp_iters = iter_cnt_q;
                if (out_resp_rdy) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pagerank_iter_sched.sv
// ---------------------------------------------------------------------------
// tb_pagerank_iter_sched
//
// Bench for pagerank_iter_sched. An in-order engine model answers each
// accepted update request after a configurable number of cycles. Expected
// engine requests, bank writes and completion responses are queued when a
// run is started and popped as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_pagerank_iter_sched;

    localparam int NODES     = 8;
    localparam int ITER_BITS = 8;
    localparam int MAX_OUT   = 4;
    localparam int NW        = $clog2(NODES);
    localparam logic [1:0] ST_SWAP = 2'd2;

    logic                 clk;
    logic                 reset;
    logic                 in_req_val;
    logic                 in_req_rdy;
    logic [ITER_BITS-1:0] in_req_iters;
    logic                 out_resp_val;
    logic                 out_resp_rdy;
    logic                 out_resp_bank;
    logic [ITER_BITS-1:0] out_resp_iters;
    logic                 eng_req_val;
    logic                 eng_req_rdy;
    logic [NW-1:0]        eng_req_node;
    logic                 eng_req_bank;
    logic                 eng_resp_val;
    logic                 eng_resp_rdy;
    logic                 wr_en;
    logic                 wr_bank;
    logic [NW-1:0]        wr_node;
    logic [1:0]           fsm_state;

    pagerank_iter_sched #(
        .NODES     (NODES),
        .ITER_BITS (ITER_BITS),
        .MAX_OUT   (MAX_OUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_req_val     (in_req_val),
        .in_req_rdy     (in_req_rdy),
        .in_req_iters   (in_req_iters),
        .out_resp_val   (out_resp_val),
        .out_resp_rdy   (out_resp_rdy),
        .out_resp_bank  (out_resp_bank),
        .out_resp_iters (out_resp_iters),
        .eng_req_val    (eng_req_val),
        .eng_req_rdy    (eng_req_rdy),
        .eng_req_node   (eng_req_node),
        .eng_req_bank   (eng_req_bank),
        .eng_resp_val   (eng_resp_val),
        .eng_resp_rdy   (eng_resp_rdy),
        .wr_en          (wr_en),
        .wr_bank        (wr_bank),
        .wr_node        (wr_node),
        .fsm_state      (fsm_state)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard queues ----------------
    logic [NW:0]        exp_req_q[$];   // {source bank, node}
    logic [NW:0]        exp_wr_q[$];    // {dest bank, node}
    logic [ITER_BITS:0] exp_resp_q[$];  // {final bank, iterations}

    // ---------------- engine model ----------------
    int eng_q[$];        // due cycle of each in-flight result, in order
    int dly_min  = 1;
    int dly_max  = 1;
    bit rand_rdy = 1'b0;
    int peak     = 0;
    int swap_cnt = 0;
    int req_cnt  = 0;

    always @(posedge clk) begin
        #1;
        eng_req_rdy  = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        eng_resp_val = (eng_q.size() > 0) && (eng_q[0] <= cyc);
    end

    // Observes the handshakes that complete at the next rising edge.
    logic [NW:0]        e_rw;
    logic [ITER_BITS:0] e_rs;
    always @(negedge clk) begin
        if (reset) begin
            eng_q.delete();
        end else begin
            if (fsm_state == ST_SWAP) swap_cnt++;
            if (eng_req_val) req_cnt++;

            if (wr_en) begin
                if (exp_wr_q.size() == 0) begin
                    check("wr_extra", int'(wr_en), 0);
                end else begin
                    e_rw = exp_wr_q.pop_front();
                    check("wr_bank_node", int'({wr_bank, wr_node}), int'(e_rw));
                end
            end

            if (eng_req_val && eng_req_rdy) begin
                if (exp_req_q.size() == 0) begin
                    check("req_extra", int'(eng_req_val), 0);
                end else begin
                    e_rw = exp_req_q.pop_front();
                    check("req_bank_node", int'({eng_req_bank, eng_req_node}), int'(e_rw));
                end
            end

            if (eng_resp_val && eng_resp_rdy && eng_q.size() > 0) begin
                void'(eng_q.pop_front());
            end
            if (eng_req_val && eng_req_rdy) begin
                eng_q.push_back(cyc + $urandom_range(dly_min, dly_max));
                if (eng_q.size() > peak) peak = eng_q.size();
            end

            if (out_resp_val && out_resp_rdy) begin
                if (exp_resp_q.size() == 0) begin
                    check("resp_extra", int'(out_resp_val), 0);
                end else begin
                    e_rs = exp_resp_q.pop_front();
                    check("resp_bank_iters", int'({out_resp_bank, out_resp_iters}), int'(e_rs));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_expect(input int iters);
        logic b;
        logic [ITER_BITS-1:0] iv;
        iv = ITER_BITS'(iters);
        for (int it = 0; it < iters; it++) begin
            b = it[0];
            for (int n = 0; n < NODES; n++) begin
                exp_req_q.push_back({b, n[NW-1:0]});
                exp_wr_q.push_back({~b, n[NW-1:0]});
            end
        end
        exp_resp_q.push_back({iv[0], iv});
    endtask

    task automatic send_req(input logic [ITER_BITS-1:0] iv, output int go_cyc);
        int t = 0;
        in_req_val   = 1'b1;
        in_req_iters = iv;
        @(negedge clk);
        while (!in_req_rdy && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("req_accept", int'(in_req_rdy), 1);
        go_cyc = cyc;
        @(posedge clk);
        #1;
        in_req_val = 1'b0;
    endtask

    task automatic run_job(input int iters, input int dmin, input int dmax,
                           input bit rrdy, input int exp_lat);
        int go_cyc;
        int t;
        logic [ITER_BITS-1:0] iv;
        iv       = ITER_BITS'(iters);
        dly_min  = dmin;
        dly_max  = dmax;
        rand_rdy = rrdy;
        swap_cnt = 0;
        peak     = 0;
        push_expect(iters);
        send_req(iv, go_cyc);

        t = 0;
        while (!out_resp_val && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("resp_seen", int'(out_resp_val), 1);
        if (exp_lat > 0) check("resp_latency", cyc - go_cyc, exp_lat);
        check("done_in_rdy_low", int'(in_req_rdy), 0);

        // Sink stalls; the completion must hold steady.
        @(negedge clk);
        @(negedge clk);
        check("done_hold_val", int'(out_resp_val), 1);
        check("done_hold_bank", int'(out_resp_bank), int'(iv[0]));
        check("done_hold_iters", int'(out_resp_iters), iters);

        @(posedge clk);
        #1;
        out_resp_rdy = 1'b1;
        @(posedge clk);
        #1;
        out_resp_rdy = 1'b0;

        check("back_idle_rdy", int'(in_req_rdy), 1);
        check("back_idle_val", int'(out_resp_val), 0);
        check("req_q_drained", exp_req_q.size(), 0);
        check("wr_q_drained", exp_wr_q.size(), 0);
        check("resp_q_drained", exp_resp_q.size(), 0);
        check("swap_count", swap_cnt, iters);
        check("peak_within_max", int'(peak <= MAX_OUT), 1);
        rand_rdy = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_rdy"}, int'(in_req_rdy), 1);
        check({tag, "_eng_val"}, int'(eng_req_val), 0);
        check({tag, "_out_val"}, int'(out_resp_val), 0);
        check({tag, "_resp_rdy"}, int'(eng_resp_rdy), 0);
        check({tag, "_wr_en"}, int'(wr_en), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int r0;
        int go_cyc;
        int t;

        reset        = 1'b1;
        in_req_val   = 1'b0;
        in_req_iters = '0;
        out_resp_rdy = 1'b0;
        eng_req_rdy  = 1'b0;
        eng_resp_val = 1'b0;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_bank", int'(out_resp_bank), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("post_reset");

        // Single iteration, zero-stall engine.
        run_job(1, 1, 1, 1'b0, 11);

        // Three iterations: source banks 0,1,0; three swaps.
        run_job(3, 1, 1, 1'b0, 31);

        // Zero iterations: immediate completion, no engine traffic.
        r0 = req_cnt;
        run_job(0, 1, 1, 1'b0, 1);
        check("zero_no_eng_req", req_cnt - r0, 0);

        // Slow engine: window fills to exactly MAX_OUT.
        run_job(1, 6, 6, 1'b0, 0);
        check("slow_peak", peak, MAX_OUT);

        // Random engine ready and response delay.
        run_job($urandom_range(2, 4), 1, 4, 1'b1, 0);

        // Reset in the middle of a run, right after node 5 is written.
        dly_min = 1;
        dly_max = 1;
        push_expect(2);
        send_req(ITER_BITS'(2), go_cyc);
        t = 0;
        @(negedge clk);
        while (!(wr_en && wr_node == NW'(5)) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("mid_run_node5_seen", int'(wr_en && wr_node == NW'(5)), 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        exp_req_q.delete();
        exp_wr_q.delete();
        exp_resp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("after_mid_reset");

        run_job(2, 1, 1, 1'b0, 21);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete (checks %0d)", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
